// File: rtl/cache_types.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | cache_types : shared coherence-bus commands and controller states   |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
package cache_types;

  localparam int NUM_CACHE = 4;

  typedef enum logic [1:0] {
    BUS_RD   = 2'd0,
    BUS_RDX  = 2'd1,
    BUS_UPGR = 2'd2,
    BUS_WB   = 2'd3
  } bus_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SNOOP  = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_MEM_RD = 3'd3,
    ST_MEM_WR = 3'd4,
    ST_RESP   = 3'd5
  } bus_state_t;

endpackage
`default_nettype wire

// File: rtl/bus_controller_if.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | bus_controller_if : request, snoop, memory and response bundle      |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
interface bus_controller_if
  import cache_types::*;
#(
  parameter int NUM_NODES  = NUM_CACHE,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) ();

  logic     [NUM_NODES-1:0]                 gnt;
  logic     [NUM_NODES-1:0]                 busy;
  bus_cmd_t [NUM_NODES-1:0]                 req_cmd;
  logic     [NUM_NODES-1:0][ADDR_WIDTH-1:0] req_addr;
  logic     [NUM_NODES-1:0][LINE_WIDTH-1:0] req_wdata;

  logic                                     snoop_valid;
  bus_cmd_t                                 snoop_cmd;
  logic     [ADDR_WIDTH-1:0]                snoop_addr;
  logic     [NUM_NODES-1:0]                 snoop_src;
  logic     [NUM_NODES-1:0]                 snoop_ack;
  logic     [NUM_NODES-1:0]                 snoop_shared;
  logic     [NUM_NODES-1:0]                 snoop_dirty;
  logic     [NUM_NODES-1:0][LINE_WIDTH-1:0] snoop_data;

  logic                                     mem_read;
  logic                                     mem_write;
  logic     [ADDR_WIDTH-1:0]                mem_addr;
  logic     [LINE_WIDTH-1:0]                mem_wdata;
  logic     [LINE_WIDTH-1:0]                mem_rdata;
  logic                                     mem_resp;

  logic     [NUM_NODES-1:0]                 rsp_valid;
  logic     [LINE_WIDTH-1:0]                rsp_data;
  logic                                     rsp_shared;

  modport master (
    input  gnt, req_cmd, req_addr, req_wdata,
    input  snoop_ack, snoop_shared, snoop_dirty, snoop_data,
    input  mem_rdata, mem_resp,
    output busy, snoop_valid, snoop_cmd, snoop_addr, snoop_src,
    output mem_read, mem_write, mem_addr, mem_wdata,
    output rsp_valid, rsp_data, rsp_shared
  );

  modport slave (
    output gnt, req_cmd, req_addr, req_wdata,
    output snoop_ack, snoop_shared, snoop_dirty, snoop_data,
    output mem_rdata, mem_resp,
    input  busy, snoop_valid, snoop_cmd, snoop_addr, snoop_src,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    input  rsp_valid, rsp_data, rsp_shared
  );

endinterface
`default_nettype wire

// File: rtl/bus_controller_snoop_collector.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | snoop_collector : sticky snoop ack/shared/dirty and dirty-line pick |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
module snoop_collector #(
  parameter int NUM_NODES  = 4,
  parameter int LINE_WIDTH = 256
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clear,
  input  logic                                 enable,
  input  logic [NUM_NODES-1:0]                 owner_oh,
  input  logic [NUM_NODES-1:0]                 ack,
  input  logic [NUM_NODES-1:0]                 shared,
  input  logic [NUM_NODES-1:0]                 dirty,
  input  logic [NUM_NODES-1:0][LINE_WIDTH-1:0] data,
  output logic                                 all_acked,
  output logic                                 any_shared,
  output logic                                 any_dirty,
  output logic [LINE_WIDTH-1:0]                dirty_data
);

  logic [NUM_NODES-1:0]  r_acked;
  logic                  r_shared;
  logic                  r_dirty;
  logic [LINE_WIDTH-1:0] r_data;

  logic [NUM_NODES-1:0]  w_ack_peer;
  logic [NUM_NODES-1:0]  w_dirty_now;
  logic [LINE_WIDTH-1:0] w_new_data;

  // Flags include the current-cycle acks so the FSM can leave in the ack cycle.
  always_comb begin
    w_ack_peer  = enable ? (ack & ~owner_oh) : '0;
    w_dirty_now = w_ack_peer & dirty;
    w_new_data  = r_data;
    for (int i = NUM_NODES - 1; i >= 0; i--) begin
      if (w_dirty_now[i]) w_new_data = data[i];
    end
    all_acked  = &(r_acked | w_ack_peer | owner_oh);
    any_shared = r_shared | (|(w_ack_peer & shared));
    any_dirty  = r_dirty | (|w_dirty_now);
    dirty_data = r_dirty ? r_data : w_new_data;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_acked  <= '0;
      r_shared <= 1'b0;
      r_dirty  <= 1'b0;
      r_data   <= '0;
    end else if (enable) begin
      r_acked  <= r_acked | w_ack_peer;
      r_shared <= any_shared;
      r_dirty  <= any_dirty;
      r_data   <= dirty_data;
    end
  end

  a_single_dirty: assert property (@(posedge clk) disable iff (rst)
    $onehot0(w_dirty_now) && !(r_dirty && (|w_dirty_now)));

endmodule
`default_nettype wire

// File: rtl/bus_controller.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | bus_controller : coherence-bus transaction engine (snoop/mem/resp)  |
// | Option macro BUS_C2C_XFER_EN: dirty peer answers before the flush.  |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
module bus_controller
  import cache_types::*;
#(
  parameter int NUM_NODES  = NUM_CACHE,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input logic              clk,
  input logic              rst,
  bus_controller_if.master bus
);

  localparam int IDX_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;

  bus_state_t            r_state;
  logic [NUM_NODES-1:0]  r_owner_oh;
  bus_cmd_t              r_cmd;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_busy;
  logic                  r_snoop_valid;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic [LINE_WIDTH-1:0] r_mem_wdata;
  logic [NUM_NODES-1:0]  r_rsp_valid;
  logic [LINE_WIDTH-1:0] r_rsp_data;
  logic                  r_rsp_shared;
  logic                  r_flush_pend;

  logic [IDX_W-1:0]      w_gnt_idx;
  logic [NUM_NODES-1:0]  w_gnt_oh;
  logic                  w_grant;
  logic                  w_all_acked;
  logic                  w_any_shared;
  logic                  w_any_dirty;
  logic                  w_rsp_shared;
  logic [LINE_WIDTH-1:0] w_dirty_data;

  // Lowest granted index wins if the arbiter ever misbehaves.
  always_comb begin
    w_gnt_idx = '0;
    w_gnt_oh  = '0;
    for (int i = NUM_NODES - 1; i >= 0; i--) begin
      if (bus.gnt[i]) begin
        w_gnt_idx   = IDX_W'(i);
        w_gnt_oh    = '0;
        w_gnt_oh[i] = 1'b1;
      end
    end
  end

  assign w_grant      = (r_state == ST_IDLE) && (|bus.gnt);
  assign w_rsp_shared = (r_cmd == BUS_RD) && (w_any_shared || w_any_dirty);

  snoop_collector #(
    .NUM_NODES  (NUM_NODES),
    .LINE_WIDTH (LINE_WIDTH)
  ) u_collector (
    .clk        (clk),
    .rst        (rst),
    .clear      (w_grant),
    .enable     (r_state == ST_SNOOP),
    .owner_oh   (r_owner_oh),
    .ack        (bus.snoop_ack),
    .shared     (bus.snoop_shared),
    .dirty      (bus.snoop_dirty),
    .data       (bus.snoop_data),
    .all_acked  (w_all_acked),
    .any_shared (w_any_shared),
    .any_dirty  (w_any_dirty),
    .dirty_data (w_dirty_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_owner_oh    <= '0;
      r_cmd         <= BUS_RD;
      r_addr        <= '0;
      r_busy        <= 1'b0;
      r_snoop_valid <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_wdata   <= '0;
      r_rsp_valid   <= '0;
      r_rsp_data    <= '0;
      r_rsp_shared  <= 1'b0;
      r_flush_pend  <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_owner_oh   <= w_gnt_oh;
            r_cmd        <= bus.req_cmd[w_gnt_idx];
            r_addr       <= bus.req_addr[w_gnt_idx];
            r_busy       <= 1'b1;
            r_flush_pend <= 1'b0;
            if (bus.req_cmd[w_gnt_idx] == BUS_WB) begin
              r_state     <= ST_MEM_WR;
              r_mem_write <= 1'b1;
              r_mem_wdata <= bus.req_wdata[w_gnt_idx];
            end else begin
              r_state       <= ST_SNOOP;
              r_snoop_valid <= 1'b1;
            end
          end
        end
        ST_SNOOP: begin
          if (w_all_acked) begin
            r_snoop_valid <= 1'b0;
            if (r_cmd == BUS_UPGR) begin
              r_state      <= ST_RESP;
              r_rsp_valid  <= r_owner_oh;
              r_rsp_shared <= 1'b0;
            end else if (w_any_dirty) begin
              r_mem_wdata <= w_dirty_data;
`ifdef BUS_C2C_XFER_EN
              r_state      <= ST_RESP;
              r_rsp_valid  <= r_owner_oh;
              r_rsp_data   <= w_dirty_data;
              r_rsp_shared <= w_rsp_shared;
              r_flush_pend <= 1'b1;
`else
              r_state     <= ST_FLUSH;
              r_mem_write <= 1'b1;
`endif
            end else begin
              r_state    <= ST_MEM_RD;
              r_mem_read <= 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          if (bus.mem_resp) begin
            r_mem_write <= 1'b0;
            if (r_flush_pend) begin
              r_state      <= ST_IDLE;
              r_busy       <= 1'b0;
              r_flush_pend <= 1'b0;
            end else begin
              r_state    <= ST_MEM_RD;
              r_mem_read <= 1'b1;
            end
          end
        end
        ST_MEM_RD: begin
          if (bus.mem_resp) begin
            r_mem_read   <= 1'b0;
            r_rsp_data   <= bus.mem_rdata;
            r_state      <= ST_RESP;
            r_rsp_valid  <= r_owner_oh;
            r_rsp_shared <= w_rsp_shared;
          end
        end
        ST_MEM_WR: begin
          if (bus.mem_resp) begin
            r_mem_write  <= 1'b0;
            r_state      <= ST_RESP;
            r_rsp_valid  <= r_owner_oh;
            r_rsp_shared <= 1'b0;
          end
        end
        ST_RESP: begin
          r_rsp_shared <= 1'b0;
          // A cache-to-cache answer still owes memory its write-back.
          if (r_flush_pend) begin
            r_state     <= ST_FLUSH;
            r_mem_write <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy ? r_owner_oh : '0;
  assign bus.snoop_valid = r_snoop_valid;
  assign bus.snoop_cmd   = r_cmd;
  assign bus.snoop_addr  = r_addr;
  assign bus.snoop_src   = r_owner_oh;
  assign bus.mem_read    = r_mem_read;
  assign bus.mem_write   = r_mem_write;
  assign bus.mem_addr    = r_addr;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_data    = r_rsp_data;
  assign bus.rsp_shared  = r_rsp_shared;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst)
    (r_state == ST_IDLE) |-> $onehot0(bus.gnt));

  c_gnt_while_busy: cover property (@(posedge clk) disable iff (rst)
    (r_state != ST_IDLE) && (|bus.gnt));

endmodule
`default_nettype wire

// File: doc/bus_controller.md
# bus_controller

Shared coherence-bus transaction engine between the round-robin bus arbiter and the private caches and memory. Latches the request of the node the arbiter grants, broadcasts it as a snoop to all other caches, and collects their responses. Sources the line from memory or a dirty peer, returns it to the requester, and holds `busy` to freeze arbitration for the whole transaction.

## Interface
- `NUM_NODES`, default `NUM_CACHE`: number of caches on the bus
- `ADDR_WIDTH`, default 32: line address width
- `LINE_WIDTH`, default 256: cache line width
- `clk  in  1`: single clock
- `rst  in  1`: reset; synchronous, active-high
- `gnt  in  NUM_NODES`: one-hot grant from the arbiter
- `busy  out  NUM_NODES`: bit n set while node n owns the bus; feeds the arbiter `busy`
- `req_cmd  in  [NUM_NODES] bus_cmd_t`: per-node command (BUS_RD, BUS_RDX, BUS_UPGR, BUS_WB)
- `req_addr  in  [NUM_NODES] ADDR_WIDTH`: per-node line address
- `req_wdata  in  [NUM_NODES] LINE_WIDTH`: per-node eviction data (BUS_WB only)
- `snoop_valid  out  1`: snoop broadcast active
- `snoop_cmd  out  bus_cmd_t`: broadcast command
- `snoop_addr  out  ADDR_WIDTH`: broadcast address
- `snoop_src  out  NUM_NODES`: one-hot owner; the owner does not snoop itself
- `snoop_ack  in  NUM_NODES`: per-node snoop complete
- `snoop_shared  in  NUM_NODES`: node holds the line clean; valid with ack
- `snoop_dirty  in  NUM_NODES`: node holds the line modified; valid with ack
- `snoop_data  in  [NUM_NODES] LINE_WIDTH`: dirty line; valid with ack
- `mem_read`, `mem_write  out  1`: memory request, held until `mem_resp`
- `mem_addr  out  ADDR_WIDTH`, `mem_wdata  out  LINE_WIDTH`: memory request payload
- `mem_rdata  in  LINE_WIDTH`, `mem_resp  in  1`: memory completion
- `rsp_valid  out  NUM_NODES`: one-cycle completion pulse to the owner
- `rsp_data  out  LINE_WIDTH`, `rsp_shared  out  1`: line, and whether any peer kept a copy

## Operation
- States: IDLE, SNOOP, FLUSH, MEM_RD, MEM_WR, RESP.
- IDLE, `gnt` nonzero:
  - Latch owner index, cmd, addr and wdata from that node.
  - Clear the ack/shared/dirty sticky registers.
  - Go to MEM_WR if BUS_WB, else SNOOP.
  - A multi-hot `gnt` is an assertion failure; the lowest index wins.
- SNOOP:
  - `snoop_valid`=1; `snoop_*` come from the latched request.
  - Acks from non-owner nodes OR into a sticky `acked` register; shared/dirty/data are captured in the ack cycle.
  - Exit when every non-owner bit is acked, including the ack in the current cycle. With NUM_NODES=1, exit after one cycle.
  - Exit to RESP if BUS_UPGR (no data); to FLUSH if any captured dirty; otherwise to MEM_RD.
  - More than one dirty node is an assertion failure; the lowest index supplies data.
- FLUSH: `mem_write` of the dirty data to the latched address; on `mem_resp` go to MEM_RD.
- MEM_RD: `mem_read`; on `mem_resp` capture `mem_rdata` and go to RESP.
- MEM_WR: `mem_write` of the owner's wdata; on `mem_resp` go to RESP.
- RESP:
  - `rsp_valid[owner]`=1 for one cycle.
  - `rsp_shared` = OR of captured shared|dirty, forced 0 for BUS_RDX/BUS_UPGR/BUS_WB.
  - Go to IDLE.
- `busy[owner]` is registered: high from the cycle after the grant through the RESP cycle inclusive, and 0 in IDLE.
- `gnt` outside IDLE is ignored and flagged by an assertion.

## Timing
- Reset: state IDLE; `busy`, `snoop_valid`, `mem_read`, `mem_write`, `rsp_valid`, `rsp_shared` = 0; data/addr outputs = 0.
- Reset mid-transaction abandons it: no `rsp_valid`, memory strobes drop in the next cycle.
- Grant in cycle G:
  - Transaction-type cycles (SNOOP/MEM_WR) start at G+1.
  - Minimum `rsp_valid` cycle: BUS_UPGR G+2, BUS_WB G+2, clean BUS_RD G+3.
  - Each extra memory/ack wait cycle adds one cycle.
- `mem_resp` is accepted in the first cycle of the memory state.
- The requester holds `req` through `rsp_valid` and drops it the next cycle. No re-grant is possible before then, because `busy` is high through RESP.
- Back-to-back transactions: IDLE lasts at least one cycle between them.

## Configuration
- `BUS_C2C_XFER_EN` defined:
  - Dirty snoop goes SNOOP -> RESP, with `rsp_data` = peer's `snoop_data`.
  - Then FLUSH writes memory and returns to IDLE; `busy` stays high through FLUSH.
  - Nominal: BUS_RD with a dirty peer gives `rsp_valid` at G+2.
- Undefined: dirty snoop goes SNOOP -> FLUSH -> MEM_RD -> RESP.

## Structure
- `cache_types` holds `NUM_CACHE`, `bus_cmd_t`, and the state enum `bus_state_t`.
- One sub-module, `snoop_collector`: sticky ack/shared/dirty registers, dirty-data select and the all-acked flag.

## Test plan
- BUS_RD from node 1, peers ack clean at G+1, `mem_resp` at G+2 -> `rsp_valid`=4'b0010 at G+3, `rsp_shared`=0, data = `mem_rdata`.
- BUS_RD from node 0, node 2 acks dirty with 0xAA.. ->
  - Macro off: memory write of 0xAA.., then memory read, then `rsp_data`=0xAA...
  - Macro on: `rsp_valid` at G+2 with 0xAA.., then memory write.
- BUS_UPGR from node 3, node 1 acks shared, staggered ack cycles -> no memory access; `rsp_valid` one cycle after the last ack.
- BUS_WB from node 2, `mem_resp` delayed 5 cycles -> `busy`=4'b0100 held for the whole transaction; a `gnt` pulse mid-transaction is ignored.
- `rst` asserted in MEM_RD -> all outputs 0 next cycle, no `rsp_valid`; a new grant afterwards completes normally.
